// File: rtl/mw_pkg.sv
// Shared types and constants for the microwave controller: state encoding,
// BCD digit geometry and keypad decode helpers.
package mw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DIGIT_W      = 4;
    localparam int SEC_TENS_MAX = 5;
    localparam int POWER_FULL   = 10;

    function automatic logic is_onehot(input logic [9:0] k);
        return (k != '0) && ((k & (k - 10'd1)) == '0);
    endfunction

    function automatic logic [3:0] key_digit(input logic [9:0] k);
        logic [3:0] d;
        d = '0;
        for (int i = 0; i < 10; i++)
            if (k[i]) d = 4'(i);
        return d;
    endfunction

endpackage

// File: rtl/mw_bcd_countdown.sv
// BCD mm:ss down-counter chain with shift-in entry; sec_tens wraps to 5,
// every other digit wraps to 9. Holds at zero.
import mw_pkg::*;

module mw_bcd_countdown #(
    parameter int MIN_DIGITS = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  clear,
    input  logic                                  load,
    input  logic [DIGIT_W-1:0]                    digit,
    input  logic                                  tick,
    output logic [DIGIT_W*(MIN_DIGITS+2)-1:0]     digits,
    output logic                                  zero
);

    localparam int N = MIN_DIGITS + 2;

    logic [N-1:0][DIGIT_W-1:0] d_q, dec_d;
    logic                      run;

    assign digits = d_q;
    assign zero   = (d_q == '0);

    // Borrow ripples upward only through digits that are currently zero.
    always_comb begin
        dec_d = d_q;
        run   = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (run) begin
                if (d_q[i] == '0) begin
                    dec_d[i] = (i == 1) ? DIGIT_W'(SEC_TENS_MAX) : DIGIT_W'(9);
                end else begin
                    dec_d[i] = d_q[i] - DIGIT_W'(1);
                    run      = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear)
            d_q <= '0;
        else if (load)
            d_q <= {d_q[N-2:0], digit};
        else if (tick && !zero)
            d_q <= dec_d;
    end

endmodule

// File: rtl/micro_waves_control_p.sv
// Microwave controller top: button/keypad edge detect, cook FSM, 1 Hz prescaler
// and magnetron gating. Optional power levels under `POWER_LEVEL_EN`.
import mw_pkg::*;

module micro_waves_control_p #(
    parameter int CLK_FREQ_HZ = 1000,
    parameter int MIN_DIGITS  = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  startn,
    input  logic                                  stopn,
    input  logic                                  clearn,
    input  logic                                  door_closed,
    input  logic [9:0]                            keypad,
`ifdef POWER_LEVEL_EN
    input  logic                                  power_n,
    output logic [3:0]                            power_lvl,
`endif
    output logic [DIGIT_W*(MIN_DIGITS+2)-1:0]     time_bcd,
    output logic                                  mag_on,
    output logic                                  done,
    output logic [2:0]                            state
);

    localparam int TW = DIGIT_W * (MIN_DIGITS + 2);
    localparam int PW = $clog2(CLK_FREQ_HZ);

    state_t      st_q, st_n;
    logic        start_q, stop_q, clear_q;
    logic [9:0]  key_q;
    logic        start_ev, stop_ev, clear_ev, key_ev;
    logic [PW-1:0] presc_q;
    logic        tick, load, clr, dec, zero, last;

    assign start_ev = start_q & ~startn;
    assign stop_ev  = stop_q  & ~stopn;
    assign clear_ev = clear_q & ~clearn;
    assign key_ev   = is_onehot(keypad) && (keypad != key_q);
    assign tick     = (st_q == ST_COOK) && (presc_q == PW'(CLK_FREQ_HZ - 1));
    assign last     = (time_bcd == TW'(1));

`ifdef POWER_LEVEL_EN
    logic       pwr_q, pwr_ev, arm_q, arm_d, lvl_wr;
    logic [3:0] lvl_q, win_q;
    assign pwr_ev    = pwr_q & ~power_n;
    assign power_lvl = lvl_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q    <= ST_IDLE;
            start_q <= 1'b1;
            stop_q  <= 1'b1;
            clear_q <= 1'b1;
            key_q   <= '0;
        end else begin
            st_q    <= st_n;
            start_q <= startn;
            stop_q  <= stopn;
            clear_q <= clearn;
            key_q   <= keypad;
        end
    end

    // Prescaler restarts on every entry to COOK so a resumed cook gets a full second.
    always_ff @(posedge clk) begin
        if (reset)
            presc_q <= '0;
        else if (st_q != ST_COOK && st_n == ST_COOK)
            presc_q <= '0;
        else if (st_q == ST_COOK)
            presc_q <= tick ? '0 : presc_q + PW'(1);
    end

    always_comb begin
        st_n = st_q;
        load = 1'b0;
        clr  = 1'b0;
        dec  = 1'b0;
`ifdef POWER_LEVEL_EN
        arm_d  = arm_q;
        lvl_wr = 1'b0;
`endif
        if (clear_ev) begin
            st_n = ST_IDLE;
            clr  = 1'b1;
        end else begin
            case (st_q)
                ST_IDLE, ST_SET: begin
                    if (start_ev) begin
                        if (st_q == ST_SET && door_closed && !zero) st_n = ST_COOK;
                    end
`ifdef POWER_LEVEL_EN
                    else if (pwr_ev && st_q == ST_SET) arm_d = 1'b1;
                    else if (key_ev && arm_q) begin
                        lvl_wr = 1'b1;
                        arm_d  = 1'b0;
                    end
`endif
                    else if (key_ev) begin
                        load = 1'b1;
                        st_n = ST_SET;
                    end
                end
                ST_COOK: begin
                    if (!door_closed || stop_ev) st_n = ST_PAUSE;
                    else if (tick) begin
                        dec = 1'b1;
                        if (last) st_n = ST_DONE;
                    end
                end
                ST_PAUSE: begin
                    if (stop_ev) begin
                        st_n = ST_IDLE;
                        clr  = 1'b1;
                    end else if (start_ev && door_closed) begin
                        st_n = ST_COOK;
                    end
                end
                ST_DONE: begin
                    if (stop_ev || start_ev || key_ev
`ifdef POWER_LEVEL_EN
                        || pwr_ev
`endif
                    ) begin
                        st_n = ST_IDLE;
                        load = key_ev && !stop_ev && !start_ev;
                    end
                end
                default: st_n = ST_IDLE;
            endcase
        end
    end

`ifdef POWER_LEVEL_EN
    // Duty window: 0..9 seconds, magnetron enabled while window < level.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwr_q <= 1'b1;
            arm_q <= 1'b0;
            lvl_q <= 4'(POWER_FULL);
            win_q <= '0;
        end else begin
            pwr_q <= power_n;
            arm_q <= (st_n == ST_SET) ? arm_d : 1'b0;
            if (lvl_wr)
                lvl_q <= (key_digit(keypad) == 4'd0) ? 4'(POWER_FULL) : key_digit(keypad);
            if (st_q != ST_COOK && st_n == ST_COOK)
                win_q <= '0;
            else if (dec)
                win_q <= (win_q == 4'd9) ? 4'd0 : win_q + 4'd1;
        end
    end
    assign mag_on = (st_q == ST_COOK) && door_closed && (win_q < lvl_q);
`else
    assign mag_on = (st_q == ST_COOK) && door_closed;
`endif

    assign done  = (st_q == ST_DONE);
    assign state = st_q;

    mw_bcd_countdown #(.MIN_DIGITS(MIN_DIGITS)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (clr),
        .load   (load),
        .digit  (key_digit(keypad)),
        .tick   (dec),
        .digits (time_bcd),
        .zero   (zero)
    );

endmodule

// File: tb/tb_micro_waves_control_p.sv
// Directed bench for micro_waves_control_p at CLK_FREQ_HZ=4, MIN_DIGITS=1.
module tb_micro_waves_control_p;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startn = 1'b1, stopn = 1'b1, clearn = 1'b1;
    logic        door_closed = 1'b1;
    logic [9:0]  keypad = '0;
    logic [11:0] time_bcd;
    logic        mag_on, done;
    logic [2:0]  state;
`ifdef POWER_LEVEL_EN
    logic        power_n = 1'b1;
    logic [3:0]  power_lvl;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    micro_waves_control_p #(.CLK_FREQ_HZ(4), .MIN_DIGITS(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .keypad      (keypad),
`ifdef POWER_LEVEL_EN
        .power_n     (power_n),
        .power_lvl   (power_lvl),
`endif
        .time_bcd    (time_bcd),
        .mag_on      (mag_on),
        .done        (done),
        .state       (state)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic key(input int d);
        keypad = 10'd1 << d;
        step();
        keypad = '0;
        step();
    endtask

    task automatic start_press();
        startn = 1'b0;
        step();
        startn = 1'b1;
    endtask

    task automatic clear_press();
        clearn = 1'b0;
        step();
        clearn = 1'b1;
        step();
    endtask

    initial begin
        // reset
        step(2);
        reset = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_time", time_bcd, 0);
        chk("rst_mag", mag_on, 0);
        chk("rst_done", done, 0);

        // 1) 1:30 entry and borrow chain
        key(1); key(3); key(0);
        chk("t1_entry", time_bcd, 12'h130);
        chk("t1_set", state, 1);
        start_press();
        chk("t1_cook", state, 2);
        chk("t1_mag", mag_on, 1);
        step(3);
        chk("t1_hold3", time_bcd, 12'h130);
        step();
        chk("t1_tick1", time_bcd, 12'h129);
        step(116);
        chk("t1_100", time_bcd, 12'h100);
        step(4);
        chk("t1_059", time_bcd, 12'h059);
        clear_press();
        chk("t1_clr_state", state, 0);
        chk("t1_clr_time", time_bcd, 0);
        chk("t1_clr_mag", mag_on, 0);

        // 2) 5 s cook to DONE, then digit in DONE
        key(5);
        start_press();
        chk("t2_mag", mag_on, 1);
        step(19);
        chk("t2_pre_state", state, 2);
        chk("t2_pre_time", time_bcd, 12'h001);
        step();
        chk("t2_done_state", state, 4);
        chk("t2_done", done, 1);
        chk("t2_done_mag", mag_on, 0);
        chk("t2_done_time", time_bcd, 0);
        keypad = 10'd1 << 7;
        step();
        keypad = '0;
        chk("t2_exit_state", state, 0);
        chk("t2_exit_time", time_bcd, 12'h007);
        chk("t2_exit_done", done, 0);
        step();
        clear_press();

        // 3) door open pauses, resume gets a full tick
        key(1); key(0);
        start_press();
        step(2);
        door_closed = 1'b0;
        #1;
        chk("t3_mag_gate", mag_on, 0);
        step();
        chk("t3_pause", state, 3);
        step(5);
        chk("t3_frozen", time_bcd, 12'h010);
        door_closed = 1'b1;
        start_press();
        chk("t3_resume", state, 2);
        chk("t3_resume_mag", mag_on, 1);
        step(3);
        chk("t3_hold3", time_bcd, 12'h010);
        step();
        chk("t3_tick", time_bcd, 12'h009);
        stopn = 1'b0; step(); stopn = 1'b1;
        chk("t3_stop_pause", state, 3);
        step();
        stopn = 1'b0; step(); stopn = 1'b1;
        chk("t3_stop_idle", state, 0);
        chk("t3_stop_time", time_bcd, 0);
        step();

        // 4) ignored starts and non-one-hot keypad
        keypad = 10'b0000000011;
        step();
        keypad = '0;
        step();
        chk("t4_multi_state", state, 0);
        chk("t4_multi_time", time_bcd, 0);
        key(0);
        start_press();
        step();
        chk("t4_zero_start", state, 1);
        chk("t4_zero_mag", mag_on, 0);
        key(4);
        door_closed = 1'b0;
        start_press();
        step();
        chk("t4_door_start", state, 1);
        chk("t4_door_mag", mag_on, 0);
        door_closed = 1'b1;

        // 5) clear beats start; reset mid-cook
        clearn = 1'b0; startn = 1'b0;
        step();
        clearn = 1'b1; startn = 1'b1;
        chk("t5_clr_state", state, 0);
        chk("t5_clr_time", time_bcd, 0);
        step();
        key(2);
        start_press();
        step(5);
        chk("t5_cooking", time_bcd, 12'h001);
        reset = 1'b1;
        step();
        chk("t5_rst_state", state, 0);
        chk("t5_rst_time", time_bcd, 0);
        chk("t5_rst_mag", mag_on, 0);
        chk("t5_rst_done", done, 0);
        reset = 1'b0;
        step();

`ifdef POWER_LEVEL_EN
        // 6) level 3 duty window
        chk("t6_lvl_rst", power_lvl, 10);
        key(2); key(0);
        power_n = 1'b0; step(); power_n = 1'b1; step();
        key(3);
        chk("t6_lvl", power_lvl, 3);
        chk("t6_time", time_bcd, 12'h020);
        start_press();
        for (int t = 0; t < 10; t++) begin
            chk("t6_window", mag_on, (t < 3) ? 1 : 0);
            step(4);
        end
        clear_press();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
